register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-read-port register file for the next-generation CPU datapath. It generalises the 2-read/1-write, 32×64 register file to a configurable width, depth and read-port count. Register 0 is hardwired to zero, writes are synchronous, and an optional same-cycle write-to-read bypass is available. A handshaked clear sequencer zeroes the whole file one register per cycle without asserting reset. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2
- NREAD, 2, number of independent read ports, 1..4
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- readRegister  in  NREAD×AW  read addresses, one per port
- readData  out  NREAD×XLEN  read data, combinational from readRegister
- writeRegister  in  AW  write address
- writeData  in  XLEN  write data
- regWrite  in  1  write enable, sampled on rising clk
- clearReq  in  1  request a full clear, sampled on rising clk
- clearBusy  out  1  clear sequence in progress
- clearDone  out  1  one-cycle pulse on the last clear cycle
- writeDropped  out  1  one-cycle pulse when a regWrite was ignored

## Operation
- Storage: NREGS−1 physical XLEN registers, indices 1..NREGS−1. Register 0 reads as 0. Writes to register 0 are discarded silently and do not pulse writeDropped.
- Read: readData[p] = reg[readRegister[p]], purely combinational. All ports are independent and may share an address.
- Write: when regWrite=1 and the FSM is in IDLE, reg[writeRegister] ← writeData on the rising clk.
- Clear FSM states:
  - IDLE: clearBusy=0. On clearReq=1 at an edge → CLEAR, with ptr←1.
  - CLEAR: clearBusy=1. Each edge performs reg[ptr]←0 and ptr←ptr+1. When ptr=NREGS−1, that edge clears the final register, pulses clearDone (registered, high in the following cycle), and returns to IDLE.
- Clear takes exactly NREGS−1 cycles. clearReq is ignored while in CLEAR; there is no re-queue.
- A regWrite presented in CLEAR is ignored. writeDropped is high in the next cycle, unless the write targeted register 0.
- clearReq and regWrite together in IDLE: the write commits on that edge, then the clear begins; that register is later zeroed.
- Reads during CLEAR return current contents. Registers with index < ptr read 0; the rest hold their old values.
- ptr is AW bits wide and never wraps past NREGS−1.

## Timing
- Reset values (asynchronous, immediate): all registers 0, FSM IDLE, ptr 0, clearBusy 0, clearDone 0, writeDropped 0. readData is therefore 0 for every address.
- Reset asserted mid-clear aborts the sequence: all registers zero, no clearDone pulse.
- Write-to-read latency: 1 cycle without bypass. A read of the write address in the write cycle returns the old value.
- clearBusy rises in the cycle after clearReq is sampled and stays high for NREGS−1 cycles. clearDone is high in the first IDLE cycle.
- No combinational path from clearReq, or from the FSM, to readData.

## Configuration
- REGFILE_BYPASS_EN defined: if regWrite=1, the FSM is IDLE, writeRegister≠0 and readRegister[p]=writeRegister, then readData[p]=writeData in the same cycle. This adds a combinational writeData→readData path.
- REGFILE_BYPASS_EN undefined: no forwarding; reads always return the stored value.
- Bypass never applies to register 0, and never applies during CLEAR.

## Structure
- Package regfile_pkg:
  - XLEN_DEFAULT=64, NREGS_DEFAULT=32
  - clr_state_t enum {CLR_IDLE, CLR_RUN}
  - function is_zero_reg(addr)
- Sub-module regfile_clear_fsm owns the state, ptr, clearBusy, clearDone and writeDropped. It exports a clear-write strobe and the address to the storage array.
- Top level instantiates regfile_clear_fsm, the storage array and the per-port read muxes, generated over NREAD.

## Test plan
- Reset then NREAD=2: read addresses 0, 5, 31 → readData 0 on all ports. clearBusy=0.
- Write 0xDEADBEEF_CAFEF00D to x7, read x7 next cycle on both ports → both return that value. Write 0x1234 to x0 → x0 reads 0, writeDropped stays 0.
- Same-cycle read/write of x9 with 0xA5: with REGFILE_BYPASS_EN → 0xA5 immediately; without it → old value 0, then 0xA5 a cycle later.
- Fill x1..x31 with index×3, pulse clearReq → clearBusy high 31 cycles, clearDone one pulse, all reads 0. Mid-clear (cycle 10), x20 still reads 60.
- regWrite x4=0x55 during CLEAR → writeDropped pulse next cycle, x4 reads 0 after clearDone.
- Assert rst at cycle 5 of a clear → immediate clearBusy=0, all registers 0, no clearDone. A new clearReq after release runs normally.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;
  // Addresses are zero-extended to this width before calling is_zero_reg.
  localparam int ADDR_MAX_W    = 8;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  function automatic logic is_zero_reg(input logic [ADDR_MAX_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between decode/writeback and the register file.
// The master side drives addresses, write data and controls; the slave side is the register file.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = 2
);

  localparam int AW = $clog2(NREGS);

  logic [NREAD-1:0][AW-1:0]   readRegister;
  logic [NREAD-1:0][XLEN-1:0] readData;
  logic [AW-1:0]              writeRegister;
  logic [XLEN-1:0]            writeData;
  logic                       regWrite;
  logic                       clearReq;
  logic                       clearBusy;
  logic                       clearDone;
  logic                       writeDropped;

  modport master (
    output readRegister,
    output writeRegister,
    output writeData,
    output regWrite,
    output clearReq,
    input  readData,
    input  clearBusy,
    input  clearDone,
    input  writeDropped
  );

  modport slave (
    input  readRegister,
    input  writeRegister,
    input  writeData,
    input  regWrite,
    input  clearReq,
    output readData,
    output clearBusy,
    output clearDone,
    output writeDropped
  );

endinterface

// File: rtl/register_file_mp_clear_fsm.sv
// Clear sequencer: walks ptr from 1 to NREGS-1 zeroing one register per cycle,
// and gates architectural writes so they only commit while idle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic          reg_write,
  input  logic [AW-1:0] write_register,
  output logic          write_en,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          write_dropped
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  clr_state_t    state;
  clr_state_t    state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic          done_next;
  logic          dropped_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CLR_IDLE;
      ptr           <= '0;
      clear_done    <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      clear_done    <= done_next;
      write_dropped <= dropped_next;
    end
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    done_next    = 1'b0;
    dropped_next = 1'b0;
    write_en     = 1'b0;
    clr_we       = 1'b0;
    clear_busy   = 1'b0;
    case (state)
      CLR_IDLE: begin
        write_en = reg_write;
        // A coincident write still commits on this edge; the clear zeroes it later.
        if (clear_req) begin
          state_next = CLR_RUN;
          ptr_next   = AW'(1);
        end
      end
      CLR_RUN: begin
        clear_busy   = 1'b1;
        clr_we       = 1'b1;
        dropped_next = reg_write && !is_zero_reg(ADDR_MAX_W'(write_register));
        // ptr holds at the last register instead of wrapping.
        if (ptr == LAST_REG) begin
          state_next = CLR_IDLE;
          done_next  = 1'b1;
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      default: state_next = CLR_IDLE;
    endcase
  end

  assign clr_addr = ptr;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with hardwired-zero x0, synchronous write and clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = 2
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic          write_en;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  regfile_clear_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_fsm (
    .clk            (clk),
    .rst            (rst),
    .clear_req      (bus.clearReq),
    .reg_write      (bus.regWrite),
    .write_register (bus.writeRegister),
    .write_en       (write_en),
    .clr_we         (clr_we),
    .clr_addr       (clr_addr),
    .clear_busy     (bus.clearBusy),
    .clear_done     (bus.clearDone),
    .write_dropped  (bus.writeDropped)
  );

  // Only registers 1..NREGS-1 have storage; x0 is synthesised as a constant.
  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (clr_we && (clr_addr == AW'(i))) begin
          regs[i] <= '0;
        end else if (write_en && (bus.writeRegister == AW'(i))) begin
          regs[i] <= bus.writeData;
        end
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [XLEN-1:0] stored;

    always_comb begin
      stored = '0;
      for (int i = 1; i < NREGS; i++) begin
        if (bus.readRegister[p] == AW'(i)) begin
          stored = regs[i];
        end
      end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit;
    // write_en is already low during a clear, so forwarding cannot happen then.
    assign hit = write_en && !is_zero_reg(ADDR_MAX_W'(bus.writeRegister)) &&
                 (bus.readRegister[p] == bus.writeRegister);
    assign bus.readData[p] = hit ? bus.writeData : stored;
`else
    assign bus.readData[p] = stored;
`endif
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_DROP = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          kind;
    int          port;
    logic [63:0] val;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic exp_rd(input int p, input logic [63:0] v, input string n);
    chk_t c;
    c.kind = K_RD; c.port = p; c.val = v; c.name = n;
    sb.push_back(c);
  endtask

  task automatic exp_sig(input int k, input logic v, input string n);
    chk_t c;
    c.kind = k; c.port = 0; c.val = {63'b0, v}; c.name = n;
    sb.push_back(c);
  endtask

  task automatic exp_ctrl(input logic busy, input logic done, input logic drop, input string n);
    exp_sig(K_BUSY, busy, {n, ".busy"});
    exp_sig(K_DONE, done, {n, ".done"});
    exp_sig(K_DROP, drop, {n, ".drop"});
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.readRegister[0] = 5'(a0);
    bus.readRegister[1] = 5'(a1);
  endtask

  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled at the falling edge
  chk_t        mc;
  logic [63:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      case (mc.kind)
        K_RD:    act = bus.readData[mc.port];
        K_BUSY:  act = {63'b0, bus.clearBusy};
        K_DONE:  act = {63'b0, bus.clearDone};
        default: act = {63'b0, bus.writeDropped};
      endcase
      total++;
      if (act !== mc.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", mc.name, act, mc.val, $time);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [63:0] big;

  initial begin
    big = 64'hDEADBEEF_CAFEF00D;
    rst = 1'b1;
    bus.regWrite      = 1'b0;
    bus.clearReq      = 1'b0;
    bus.writeRegister = '0;
    bus.writeData     = '0;
    set_rd(0, 5);
    exp_rd(0, 64'd0, "rst.x0");
    exp_rd(1, 64'd0, "rst.x5");
    exp_ctrl(1'b0, 1'b0, 1'b0, "rst");
    cycle();

    rst = 1'b0;
    set_rd(31, 31);
    exp_rd(0, 64'd0, "rst.x31a");
    exp_rd(1, 64'd0, "rst.x31b");
    cycle();
    total++;
    if (bus.clearBusy !== 1'b0) begin
      bad++;
      $display("FAIL idle.busy: got %b expected 0 (t=%0t)", bus.clearBusy, $time);
    end

    // Write x7, read on both ports
    bus.regWrite = 1'b1; bus.writeRegister = 5'd7; bus.writeData = big;
    set_rd(7, 7);
    exp_rd(0, BYP ? big : 64'd0, "x7.same0");
    exp_rd(1, BYP ? big : 64'd0, "x7.same1");
    cycle();
    bus.regWrite = 1'b0;
    #1;
    total++;
    if (bus.readData[0] !== big) begin
      bad++;
      $display("FAIL x7.direct: got %h expected %h (t=%0t)", bus.readData[0], big, $time);
    end
    exp_rd(0, big, "x7.next0");
    exp_rd(1, big, "x7.next1");
    cycle();

    // Write to x0 is discarded without a drop pulse
    bus.regWrite = 1'b1; bus.writeRegister = 5'd0; bus.writeData = 64'h1234;
    set_rd(0, 7);
    exp_rd(0, 64'd0, "x0.same");
    exp_rd(1, big, "x0.x7");
    exp_ctrl(1'b0, 1'b0, 1'b0, "x0w");
    cycle();
    bus.regWrite = 1'b0;
    exp_rd(0, 64'd0, "x0.next");
    exp_sig(K_DROP, 1'b0, "x0.drop");
    cycle();

    // Same-cycle read/write of x9
    bus.regWrite = 1'b1; bus.writeRegister = 5'd9; bus.writeData = 64'hA5;
    set_rd(9, 9);
    exp_rd(0, BYP ? 64'hA5 : 64'd0, "x9.same0");
    exp_rd(1, BYP ? 64'hA5 : 64'd0, "x9.same1");
    cycle();
    bus.regWrite = 1'b0;
    exp_rd(0, 64'hA5, "x9.next0");
    exp_rd(1, 64'hA5, "x9.next1");
    cycle();

    // Fill x1..x31 with index*3
    for (int i = 1; i < NREGS; i++) begin
      bus.regWrite = 1'b1; bus.writeRegister = 5'(i); bus.writeData = 64'(i * 3);
      cycle();
    end
    bus.regWrite = 1'b0;
    set_rd(20, 7);
    exp_rd(0, 64'd60, "fill.x20");
    exp_rd(1, 64'd21, "fill.x7");
    cycle();

    // Full clear, with a dropped write and an ignored clearReq along the way
    bus.clearReq = 1'b1;
    set_rd(20, 1);
    exp_rd(0, 64'd60, "clrreq.x20");
    exp_rd(1, 64'd3, "clrreq.x1");
    exp_ctrl(1'b0, 1'b0, 1'b0, "clrreq");
    cycle();
    for (int k = 1; k < NREGS; k++) begin
      bus.clearReq      = (k == 15);
      bus.regWrite      = (k == 4);
      bus.writeRegister = 5'd4;
      bus.writeData     = 64'h55;
      set_rd(20, (k == 4) ? 4 : 9);
      exp_rd(0, (k <= 20) ? 64'd60 : 64'd0, $sformatf("clr%0d.x20", k));
      if (k == 4) exp_rd(1, 64'd12, "clr4.x4");
      else        exp_rd(1, (k <= 9) ? 64'd27 : 64'd0, $sformatf("clr%0d.x9", k));
      exp_ctrl(1'b1, 1'b0, (k == 5), $sformatf("clr%0d", k));
      cycle();
    end
    bus.clearReq = 1'b0;
    bus.regWrite = 1'b0;
    set_rd(4, 31);
    exp_rd(0, 64'd0, "post.x4");
    exp_rd(1, 64'd0, "post.x31");
    exp_ctrl(1'b0, 1'b1, 1'b0, "post");
    cycle();
    for (int a = 0; a < NREGS; a++) begin
      set_rd(a, NREGS - 1 - a);
      exp_rd(0, 64'd0, $sformatf("zero.p0.x%0d", a));
      exp_rd(1, 64'd0, $sformatf("zero.p1.x%0d", NREGS - 1 - a));
      if (a == 0) exp_ctrl(1'b0, 1'b0, 1'b0, "post2");
      cycle();
    end

    // Reset in the middle of a clear
    bus.regWrite = 1'b1; bus.writeRegister = 5'd30; bus.writeData = 64'h3030;
    cycle();
    bus.writeRegister = 5'd5; bus.writeData = 64'h555;
    cycle();
    bus.regWrite = 1'b0;
    bus.clearReq = 1'b1;
    cycle();
    bus.clearReq = 1'b0;
    for (int k = 1; k < 5; k++) begin
      set_rd(5, 30);
      exp_rd(0, 64'h555, $sformatf("rclr%0d.x5", k));
      exp_rd(1, 64'h3030, $sformatf("rclr%0d.x30", k));
      exp_sig(K_BUSY, 1'b1, $sformatf("rclr%0d.busy", k));
      cycle();
    end
    rst = 1'b1;
    exp_rd(0, 64'd0, "rstmid.x5");
    exp_rd(1, 64'd0, "rstmid.x30");
    exp_ctrl(1'b0, 1'b0, 1'b0, "rstmid");
    cycle();
    exp_ctrl(1'b0, 1'b0, 1'b0, "rstmid2");
    cycle();
    rst = 1'b0;
    bus.regWrite = 1'b1; bus.writeRegister = 5'd2; bus.writeData = 64'h22;
    set_rd(2, 5);
    exp_rd(0, BYP ? 64'h22 : 64'd0, "rel.x2");
    exp_rd(1, 64'd0, "rel.x5");
    exp_ctrl(1'b0, 1'b0, 1'b0, "rel");
    cycle();
    bus.regWrite = 1'b0;
    bus.clearReq = 1'b1;
    exp_rd(0, 64'h22, "rel2.x2");
    exp_sig(K_BUSY, 1'b0, "rel2.busy");
    cycle();
    bus.clearReq = 1'b0;
    for (int k = 1; k < NREGS; k++) begin
      exp_rd(0, (k <= 2) ? 64'h22 : 64'd0, $sformatf("clr2_%0d.x2", k));
      exp_ctrl(1'b1, 1'b0, 1'b0, $sformatf("clr2_%0d", k));
      cycle();
    end
    exp_ctrl(1'b0, 1'b1, 1'b0, "end");
    cycle();
    exp_ctrl(1'b0, 1'b0, 1'b0, "end2");
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0 || total < 12) begin
      $display("FAIL summary: %0d of %0d checks failed", bad, total);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
